// File: rtl/l0_cache_invalidate_sequencer_pkg.sv
// Shared types for the L0 invalidation sequencer: FSM state encoding and the valid value written on invalidate.
package l0_cache_invalidate_sequencer_pkg;

  typedef enum logic [2:0] {
    INV_IDLE,
    INV_DRAIN,
    INV_SWEEP,
    INV_SNOOP_RD,
    INV_SNOOP_WR
  } l0_inv_state_e;

  // Replicated across every byte-valid bit of an invalidating write.
  localparam bit L0_INV_WRITE_VALID = 1'b0;

endpackage

// File: rtl/l0_cache_invalidate_sequencer_snoop_fifo.sv
// Synchronous FIFO for queued snoops; head visible combinationally, writes land one cycle after push.
// Backpressure: full derived from the registered count; a synchronous clear empties it in one cycle.
module l0_snoop_fifo #(
  parameter int Width = 14,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [Width-1:0]         push_dat,
  input  logic                     pop,
  output logic [Width-1:0]         head_dat,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PTR_ONE = PtrW'(1);
  localparam logic [PtrW:0]   CNT_ONE = (PtrW + 1)'(1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Depth is a power of two, so the count MSB alone marks full.
  assign full     = count[PtrW];
  assign empty    = ~|count;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/l0_cache_invalidate_sequencer.sv
// Owns the L0 write port for full sweeps (one line/cycle) and queued snoop invalidations (2 cycles each).
// Controller writes pass through with zero latency when idle; while busy the pipeline is held via stall.
module l0_cache_invalidate_sequencer
  import l0_cache_invalidate_sequencer_pkg::*;
#(
  parameter int               XLEN            = 32,
  parameter int               CacheIndexWidth = 7,
  parameter int               CacheTagWidth   = 7,
  parameter logic [XLEN-1:0]  MMIO_ADDR       = 32'h4000_0000,
  parameter int               SnoopDepth      = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_flush_all_req,
  output logic                        o_flush_all_done,
  input  logic                        i_snoop_valid,
  output logic                        o_snoop_ready,
  input  logic [XLEN-1:0]             i_snoop_addr,
  output logic                        o_stall_request,
  output logic                        o_busy,
  output logic                        o_conflict,
  output logic [CacheIndexWidth-1:0]  o_cache_read_index,
  input  logic [CacheTagWidth-1:0]    i_cache_read_tag,
  input  logic [XLEN/8-1:0]           i_cache_read_valid,
  input  logic                        i_ctrl_write_enable,
  input  logic [XLEN/8-1:0]           i_ctrl_byte_write_enable,
  input  logic [CacheIndexWidth-1:0]  i_ctrl_write_index,
  input  logic [XLEN-1:0]             i_ctrl_write_data,
  input  logic [CacheTagWidth-1:0]    i_ctrl_write_tag,
  input  logic [XLEN/8-1:0]           i_ctrl_write_valid,
  output logic                        o_cache_write_enable,
  output logic [XLEN/8-1:0]           o_cache_byte_write_enable,
  output logic [CacheIndexWidth-1:0]  o_cache_write_index,
  output logic [XLEN-1:0]             o_cache_write_data,
  output logic [CacheTagWidth-1:0]    o_cache_write_tag,
  output logic [XLEN/8-1:0]           o_cache_write_valid
);

  localparam int W  = CacheIndexWidth;
  localparam int T  = CacheTagWidth;
  localparam int BW = XLEN / 8;
  localparam int CW = $clog2(SnoopDepth) + 1;

  typedef struct packed {
    logic [T-1:0] tag;
    logic [W-1:0] idx;
  } snoop_ent_t;

  l0_inv_state_e   state;
  l0_inv_state_e   state_nxt;
  logic            flush_pending;
  logic [W-1:0]    sweep_idx;

  snoop_ent_t      fifo_in;
  snoop_ent_t      head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic            fifo_clear;

  logic            snoop_push;
  logic            snoop_store;
  logic            flush_want;
  logic            sweep_last;
  logic            sweep_start;
  logic            snoop_hit;
  logic            snoop_more;
  logic            own;
  logic            inv_write;

  assign fifo_in     = '{tag: i_snoop_addr[(2+W) +: T], idx: i_snoop_addr[2 +: W]};
  assign snoop_push  = i_snoop_valid & o_snoop_ready;
  // MMIO snoops are handshaken but never queued: nothing cacheable lives there.
  assign snoop_store = snoop_push & (i_snoop_addr < MMIO_ADDR);
  assign o_snoop_ready = ~fifo_full;

  assign flush_want  = flush_pending | i_flush_all_req;
  assign sweep_last  = (state == INV_SWEEP) && (sweep_idx == '1);
  assign sweep_start = (state_nxt == INV_SWEEP) && (state != INV_SWEEP);
  assign snoop_hit   = (i_cache_read_tag == head.tag) && (|i_cache_read_valid);
  assign snoop_more  = (fifo_count > CW'(1)) || snoop_store;
  // A completed sweep has invalidated every queued line as well.
  assign fifo_clear  = sweep_last;

  l0_snoop_fifo #(
    .Width (W + T),
    .Depth (SnoopDepth)
  ) u_snoop_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (fifo_clear),
    .push     (snoop_store),
    .push_dat (fifo_in),
    .pop      (fifo_pop),
    .head_dat (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= INV_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    inv_write = 1'b0;
    own       = 1'b0;
    unique case (state)
      INV_IDLE: begin
        if (flush_want || !fifo_empty) state_nxt = INV_DRAIN;
      end
      INV_DRAIN: begin
        // Let an in-flight store or fill finish before taking the port.
        if (!i_ctrl_write_enable) state_nxt = flush_want ? INV_SWEEP : INV_SNOOP_RD;
      end
      INV_SWEEP: begin
        own       = 1'b1;
        inv_write = 1'b1;
        if (sweep_last) state_nxt = INV_IDLE;
      end
      INV_SNOOP_RD: begin
        state_nxt = INV_SNOOP_WR;
      end
      INV_SNOOP_WR: begin
        own       = 1'b1;
        inv_write = snoop_hit;
        fifo_pop  = 1'b1;
        if (flush_want)      state_nxt = INV_SWEEP;
        else if (snoop_more) state_nxt = INV_SNOOP_RD;
        else                 state_nxt = INV_IDLE;
      end
      default: state_nxt = INV_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      flush_pending    <= 1'b0;
      sweep_idx        <= '0;
      o_stall_request  <= 1'b0;
      o_flush_all_done <= 1'b0;
    end else begin
      // A request arriving during a sweep survives its start-clear and re-arms a second sweep.
      if (i_flush_all_req)  flush_pending <= 1'b1;
      else if (sweep_start) flush_pending <= 1'b0;
      if (state == INV_SWEEP) sweep_idx <= sweep_idx + W'(1);
      o_stall_request  <= (state_nxt != INV_IDLE);
      o_flush_all_done <= sweep_last;
    end
  end

  assign o_cache_read_index = head.idx;
  assign o_busy     = (state != INV_IDLE) | ~fifo_empty | flush_pending;
  assign o_conflict = own & i_ctrl_write_enable;

  always_comb begin
    o_cache_write_enable      = i_ctrl_write_enable;
    o_cache_byte_write_enable = i_ctrl_byte_write_enable;
    o_cache_write_index       = i_ctrl_write_index;
    o_cache_write_data        = i_ctrl_write_data;
    o_cache_write_tag         = i_ctrl_write_tag;
    o_cache_write_valid       = i_ctrl_write_valid;
    if (own) begin
      o_cache_write_enable      = inv_write;
      o_cache_byte_write_enable = '1;
      o_cache_write_index       = (state == INV_SWEEP) ? sweep_idx : head.idx;
      o_cache_write_data        = '0;
      o_cache_write_tag         = '0;
      o_cache_write_valid       = {BW{L0_INV_WRITE_VALID}};
    end
  end

endmodule

// File: tb/tb_l0_cache_invalidate_sequencer.sv
// Directed bench for the L0 invalidation sequencer: sweeps, drain, snoop hit/miss, FIFO backpressure, re-arm, reset.
module tb_l0_cache_invalidate_sequencer;

  localparam int XLEN = 32;
  localparam int W    = 7;
  localparam int T    = 7;
  localparam int BW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_req;
  logic          flush_done;
  logic          snoop_valid;
  logic          snoop_ready;
  logic [31:0]   snoop_addr;
  logic          stall;
  logic          busy;
  logic          conflict;
  logic [W-1:0]  rd_index;
  logic [T-1:0]  rd_tag;
  logic [BW-1:0] rd_valid;
  logic          ctrl_we;
  logic [BW-1:0] ctrl_bwe;
  logic [W-1:0]  ctrl_idx;
  logic [31:0]   ctrl_data;
  logic [T-1:0]  ctrl_tag;
  logic [BW-1:0] ctrl_valid;
  logic          we;
  logic [BW-1:0] bwe;
  logic [W-1:0]  widx;
  logic [31:0]   wdata;
  logic [T-1:0]  wtag;
  logic [BW-1:0] wvalid;

  always #5 clk = ~clk;

  l0_cache_invalidate_sequencer dut (
    .i_clk                     (clk),
    .i_rst                     (rst),
    .i_flush_all_req           (flush_req),
    .o_flush_all_done          (flush_done),
    .i_snoop_valid             (snoop_valid),
    .o_snoop_ready             (snoop_ready),
    .i_snoop_addr              (snoop_addr),
    .o_stall_request           (stall),
    .o_busy                    (busy),
    .o_conflict                (conflict),
    .o_cache_read_index        (rd_index),
    .i_cache_read_tag          (rd_tag),
    .i_cache_read_valid        (rd_valid),
    .i_ctrl_write_enable       (ctrl_we),
    .i_ctrl_byte_write_enable  (ctrl_bwe),
    .i_ctrl_write_index        (ctrl_idx),
    .i_ctrl_write_data         (ctrl_data),
    .i_ctrl_write_tag          (ctrl_tag),
    .i_ctrl_write_valid        (ctrl_valid),
    .o_cache_write_enable      (we),
    .o_cache_byte_write_enable (bwe),
    .o_cache_write_index       (widx),
    .o_cache_write_data        (wdata),
    .o_cache_write_tag         (wtag),
    .o_cache_write_valid       (wvalid)
  );

  // Tag/valid array stand-in with a one-cycle synchronous read.
  logic [T-1:0]  mtag   [128];
  logic [BW-1:0] mvalid [128];
  always @(posedge clk) begin
    rd_tag   <= mtag[rd_index];
    rd_valid <= mvalid[rd_index];
  end

  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int conf_cnt = 0;
  int wr_idx_log[$];
  int wr_cyc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        wr_cnt++;
        wr_idx_log.push_back(int'(widx));
        wr_cyc_log.push_back(cyc);
      end
      if (flush_done) done_cnt++;
      if (conflict)   conf_cnt++;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, c0, bad, guard, c, first_low, low_at_i, acc5, base;
    logic found;

    for (int i = 0; i < 128; i++) begin
      mtag[i]   = '0;
      mvalid[i] = '0;
    end
    rst = 1'b1; flush_req = 1'b0; snoop_valid = 1'b0; snoop_addr = '0;
    ctrl_we = 1'b1; ctrl_bwe = 4'h3; ctrl_idx = 7'd5; ctrl_data = 32'hDEAD_BEEF;
    ctrl_tag = 7'h11; ctrl_valid = 4'h6;
    step();
    step();

    // Reset state with controller passthrough
    chk("rst_stall", stall, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", snoop_ready, 1);
    chk("rst_passthru", {we, bwe, widx, wdata, wtag, wvalid},
        {1'b1, 4'h3, 7'd5, 32'hDEAD_BEEF, 7'h11, 4'h6});
    ctrl_we = 1'b0; ctrl_bwe = '0; ctrl_idx = '0; ctrl_data = '0; ctrl_tag = '0; ctrl_valid = '0;
    rst = 1'b0;
    step();
    step();

    // Flush, controller idle: stall 1..129, sweep 2..129, done at 130 only
    w0 = wr_cnt; d0 = done_cnt;
    flush_req = 1'b1;
    chk("f1_c0_stall", stall, 0);
    step();
    flush_req = 1'b0;
    chk("f1_c1_stall", stall, 1);
    chk("f1_c1_nowrite", we, 0);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      step();
      if (!(we && widx == 7'(i) && wvalid == 4'h0 && bwe == 4'hF && wtag == '0 && wdata == '0 && stall))
        bad++;
    end
    chk("f1_sweep_writes_bad", bad, 0);
    step();
    chk("f1_done_c130", flush_done, 1);
    chk("f1_stall_c130", stall, 0);
    step();
    chk("f1_done_count", done_cnt - d0, 1);
    chk("f1_write_count", wr_cnt - w0, 128);
    chk("f1_idle_busy", busy, 0);

    // Flush while controller writes cycles 1-3: drain to 4, sweep idx0 at 5
    c0 = conf_cnt;
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0; ctrl_we = 1'b1; ctrl_idx = 7'd99; ctrl_bwe = 4'h1;
    #1;
    chk("f2_c1_passthru", {we, widx, stall}, {1'b1, 7'd99, 1'b1});
    step();
    step();
    step();
    ctrl_we = 1'b0;
    #1;
    chk("f2_c4_drain", {we, stall}, {1'b0, 1'b1});
    step();
    chk("f2_c5_sweep0", {we, widx, wvalid}, {1'b1, 7'd0, 4'h0});
    c = 5; found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      step(); c++;
      if (flush_done) found = 1'b1;
    end
    chk("f2_done_cycle", c, 133);
    chk("f2_no_conflict", conf_cnt - c0, 0);
    step();

    // Snoop hit: idx 65 tag 0, cached valid F -> single invalidate at SNOOP_WR
    mvalid[65] = 4'hF;
    w0 = wr_cnt;
    step();
    snoop_valid = 1'b1; snoop_addr = 32'h0000_0104;
    #1;
    chk("s1_ready", snoop_ready, 1);
    step();
    snoop_valid = 1'b0;
    chk("s1_c1_busy_nostall", {busy, stall}, {1'b1, 1'b0});
    step();
    chk("s1_c2_stall", stall, 1);
    step();
    chk("s1_c3_read", {rd_index, we}, {7'd65, 1'b0});
    step();
    chk("s1_c4_write", {we, widx, wvalid, bwe, conflict}, {1'b1, 7'd65, 4'h0, 4'hF, 1'b0});
    step();
    chk("s1_c5_idle", {busy, stall, we}, {1'b0, 1'b0, 1'b0});
    chk("s1_write_count", wr_cnt - w0, 1);

    // Snoop miss: cached tag 3 does not match -> no write
    mtag[65] = 7'd3;
    w0 = wr_cnt;
    step();
    snoop_valid = 1'b1; snoop_addr = 32'h0000_0104;
    step();
    snoop_valid = 1'b0;
    repeat (3) step();
    chk("s2_c4_nowrite", we, 0);
    repeat (3) step();
    chk("s2_write_count", wr_cnt - w0, 0);
    chk("s2_idle", busy, 0);

    // MMIO boundary: at MMIO_ADDR discarded, one word below queued
    step();
    snoop_valid = 1'b1; snoop_addr = 32'h4000_0000;
    #1;
    chk("mmio_ready", snoop_ready, 1);
    step();
    snoop_valid = 1'b0;
    chk("mmio_not_queued", busy, 0);
    snoop_valid = 1'b1; snoop_addr = 32'h3FFF_FFFC;
    step();
    snoop_valid = 1'b0;
    chk("below_mmio_queued", busy, 1);
    repeat (6) step();
    chk("below_mmio_drained", busy, 0);

    // Five back-to-back snoops: ready low after four, processed in order every 2 cycles
    for (int i = 0; i < 5; i++) begin
      mtag[10 + i]   = 7'd1;
      mvalid[10 + i] = 4'hF;
    end
    base = wr_idx_log.size();
    step();
    c = 0; first_low = -1; low_at_i = -1; acc5 = -1;
    for (int i = 0; i < 5; i++) begin
      snoop_valid = 1'b1;
      snoop_addr  = (32'd1 << 9) | (32'(10 + i) << 2);
      #1;
      guard = 0;
      while (!snoop_ready && guard < 20) begin
        if (first_low < 0) begin
          first_low = c;
          low_at_i  = i;
        end
        step(); c++; guard++;
      end
      if (i == 4) acc5 = c;
      step(); c++;
    end
    snoop_valid = 1'b0;
    chk("s5_ready_low_cycle", first_low, 4);
    chk("s5_ready_low_after", low_at_i, 4);
    chk("s5_fifth_accept", acc5, 5);
    repeat (12) step();
    chk("s5_write_count", wr_idx_log.size() - base, 5);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (base + i < wr_idx_log.size()) begin
        if (wr_idx_log[base + i] != 10 + i) bad++;
        if (i > 0 && wr_cyc_log[base + i] - wr_cyc_log[base + i - 1] != 2) bad++;
      end else begin
        bad++;
      end
    end
    chk("s5_order_spacing_bad", bad, 0);
    chk("s5_idle", busy, 0);

    // Flush re-armed at idx 40: two complete sweeps, one done pulse each
    w0 = wr_cnt; d0 = done_cnt; c0 = conf_cnt;
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    guard = 0;
    while (!(we && widx == 7'd40) && guard < 200) begin step(); guard++; end
    chk("m_reach_idx40", {we, widx}, {1'b1, 7'd40});
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    guard = 0;
    while (done_cnt - d0 < 1 && guard < 300) begin step(); guard++; end
    chk("m_first_done_count", done_cnt - d0, 1);
    chk("m_first_sweep_writes", wr_cnt - w0, 128);
    guard = 0;
    while (done_cnt - d0 < 2 && guard < 300) begin step(); guard++; end
    step();
    step();
    chk("m_total_dones", done_cnt - d0, 2);
    chk("m_total_writes", wr_cnt - w0, 256);
    chk("m_no_conflict", conf_cnt - c0, 0);
    chk("m_idle", busy, 0);

    // Reset at idx 60: immediate reset outputs, passthrough, no resume, no done
    w0 = wr_cnt; d0 = done_cnt;
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    guard = 0;
    while (!(we && widx == 7'd60) && guard < 200) begin step(); guard++; end
    chk("r_reach_idx60", {we, widx}, {1'b1, 7'd60});
    rst = 1'b1;
    #1;
    chk("r_async_outputs", {stall, we, busy, snoop_ready, flush_done, conflict},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    step();
    step();
    rst = 1'b0;
    ctrl_we = 1'b1; ctrl_idx = 7'd33; ctrl_data = 32'h1234_5678; ctrl_bwe = 4'hC;
    #1;
    chk("r_passthru", {we, widx, wdata, bwe}, {1'b1, 7'd33, 32'h1234_5678, 4'hC});
    ctrl_we = 1'b0;
    repeat (150) step();
    chk("r_no_done", done_cnt - d0, 0);
    chk("r_writes", wr_cnt - w0, 61);
    chk("r_idle", {busy, stall}, {1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
